// File: rtl/cpram_loader_pkg.sv
// Shared types and constants for the cpram burst-buffer fill engine.
package cpram_loader_pkg;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned DATA_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEAT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cpram_loader_if.sv
// SDRAM burst-read channel between the loader (master) and the SDRAM controller (slave).
interface cpram_loader_if
  import cpram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 27
) ();

  logic              sd_req;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_ack;
  logic              sd_valid;
  logic [DATA_W-1:0] sd_data;

  modport master (
    output sd_req,
    output sd_addr,
    input  sd_ack,
    input  sd_valid,
    input  sd_data
  );

  modport slave (
    input  sd_req,
    input  sd_addr,
    output sd_ack,
    output sd_valid,
    output sd_data
  );

endinterface

// File: rtl/cpram_loader_cnt.sv
// Beat-within-burst and words-remaining counters; flags beats that must be written.
module cpram_loader_cnt
  import cpram_loader_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [clog2(MAX_WORDS):0] load_words,
  input  logic                      clr_beat,
  input  logic                      beat,
  input  logic                      suppress,
  output logic                      wr_c,
  output logic                      last_c,
  output logic                      more_c
);

  localparam int unsigned CNT_W  = clog2(MAX_WORDS) + 1;
  localparam int unsigned BEAT_W = clog2(BURST_LEN + 1);

  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  remaining;

  // A beat is written only while words are still owed and the load is not being cancelled.
  assign wr_c   = beat && !suppress && (remaining != '0);
  assign last_c = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign more_c = (remaining > CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      remaining <= '0;
    end else begin
      if (load) begin
        remaining <= load_words;
      end else if (wr_c) begin
        remaining <= remaining - CNT_W'(1);
      end

      if (clr_beat) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= last_c ? '0 : beat_cnt + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpram_loader.sv
// Fills the 64-to-16 cpram buffer from fixed-length SDRAM burst reads.
module cpram_loader
  import cpram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [clog2(MAX_WORDS):0] num_words,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  cpram_loader_if.master            sd,
  output logic                      wr,
  output logic [DATA_W-1:0]         data
);

  localparam int unsigned       CNT_W      = clog2(MAX_WORDS) + 1;
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);

  state_t           state;
  logic [CNT_W-1:0] eff_words_c;
  logic             load_c;
  logic             clr_beat_c;
  logic             beat_c;
  logic             suppress_c;
  logic             wr_c;
  logic             last_c;
  logic             more_c;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^start_addr[2:0];

  // Zero and oversize requests both mean a full buffer.
  assign eff_words_c = ((num_words == '0) || (num_words > MAX_CNT)) ? MAX_CNT : num_words;
  assign load_c      = (state == ST_IDLE) && start;
  assign clr_beat_c  = (state == ST_REQ) && sd.sd_ack;
  assign beat_c      = sd.sd_valid && ((state == ST_BEAT) || (state == ST_DRAIN));
  assign suppress_c  = (state == ST_DRAIN) || abort;

  cpram_loader_cnt #(
    .BURST_LEN (BURST_LEN),
    .MAX_WORDS (MAX_WORDS)
  ) u_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_c),
    .load_words (eff_words_c),
    .clr_beat   (clr_beat_c),
    .beat       (beat_c),
    .suppress   (suppress_c),
    .wr_c       (wr_c),
    .last_c     (last_c),
    .more_c     (more_c)
  );

  // sd_addr doubles as the running burst address register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sd.sd_req  <= 1'b0;
      sd.sd_addr <= '0;
      wr         <= 1'b0;
      data       <= '0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sd.sd_addr <= {start_addr[ADDR_W-1:3], 3'b000};
            sd.sd_req  <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sd.sd_ack) begin
            sd.sd_req <= 1'b0;
            state     <= abort ? ST_DRAIN : ST_BEAT;
          end else if (abort) begin
            sd.sd_req <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_BEAT: begin
          if (beat_c) begin
            if (wr_c) begin
              wr   <= 1'b1;
              data <= sd.sd_data;
            end
            if (last_c) begin
              if (abort) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else if (more_c) begin
                sd.sd_addr <= sd.sd_addr + BURST_STEP;
                sd.sd_req  <= 1'b1;
                state      <= ST_REQ;
              end else begin
                state <= ST_DONE;
              end
            end else if (abort) begin
              state <= ST_DRAIN;
            end
          end else if (abort) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (beat_c && last_c) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpram_loader.md
Name: cpram_loader

Overview:
- Upstream fill engine for the 64-to-16 CPU-side burst buffer (`cpram`).
- Accepts a load command: start address plus count of 64-bit words.
- Issues one or more fixed-length SDRAM burst reads and streams the returned 64-bit beats into the buffer write port (`wr`/`data`).
- Signals completion so the consumer can begin sequential 16-bit reads.

Parameters:
- ADDR_W, 27, SDRAM byte-address width.
- BURST_LEN, 4, 64-bit beats returned per SDRAM request; power of two, 1..16.
- MAX_WORDS, 128, buffer depth in 64-bit words; power of two.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  load command strobe; sampled only in IDLE.
- start_addr  in  ADDR_W  byte address of first word; bits [2:0] ignored (treated as 0).
- num_words  in  log2(MAX_WORDS)+1  64-bit words to load; 0 means MAX_WORDS; values >MAX_WORDS clamp to MAX_WORDS.
- abort  in  1  cancel current load.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when all requested words are written.
- sd_req  out  1  SDRAM burst read request, level.
- sd_addr  out  ADDR_W  burst start byte address.
- sd_ack  in  1  one-cycle acceptance of sd_req.
- sd_valid  in  1  data beat valid.
- sd_data  in  64  data beat.
- wr  out  1  buffer write strobe.
- data  out  64  buffer write data.

Behaviour:
- Reset values: busy=0, done=0, sd_req=0, sd_addr=0, wr=0, data=0; state=IDLE; all counters 0.
- States: IDLE, REQ, BEAT, DRAIN, DONE.

IDLE:
- On start: latch addr={start_addr[ADDR_W-1:3],3'b0}, latch remaining=effective num_words, busy=1, go REQ.
- start in any other state is ignored.

REQ:
- sd_req=1 with sd_addr=addr.
- Hold both stable until sd_ack.
- On sd_ack: sd_req=0 the next cycle, beat_cnt=0, go BEAT.

BEAT:
- Each sd_valid increments beat_cnt.
- If remaining>0: register wr=1, data=sd_data (one-cycle latency, sd_valid→wr), then decrement remaining.
- If remaining=0: the beat is discarded (partial last burst), wr stays 0.
- On the BURST_LEN-th beat:
  - remaining (after decrement) >0 → addr+=BURST_LEN*8 (wraps mod 2^ADDR_W), go REQ.
  - otherwise go DONE.

DONE:
- done=1 for one cycle, busy=0 the same cycle, go IDLE.

Abort:
- In REQ: if sd_ack arrives the same cycle, go DRAIN; else drop sd_req and go IDLE.
- In BEAT: go DRAIN. The outstanding burst must be consumed so the SDRAM side stays in sync.
- In DRAIN: count remaining beats of the current burst with wr suppressed, then go IDLE. No done pulse.
- abort in IDLE/DONE has no effect.

Limits and timing:
- Total wr pulses per load are exactly the effective num_words, never more than MAX_WORDS, so the buffer write pointer never laps.
- wr is never asserted in consecutive cycles unless sd_valid was.
- No back-pressure on sd_valid.
- sd_valid outside BEAT/DRAIN is ignored.

Async reset mid-load:
- All outputs return to reset values immediately.
- The in-flight SDRAM burst is not tracked; the SDRAM controller is reset by the same reset_n.

Decomposition:
- Shared package: state enum encoding; BEAT_BYTES=8 constant; function clog2 for counter widths.
- Natural sub-module: cpram_loader_cnt, the beat/remaining counter pair with partial-burst suppression. The FSM and address generation stay in the top level.

Test Plan:
- Single burst: start_addr=0x1000, num_words=4, BURST_LEN=4, ack after 3 cycles, 4 back-to-back beats → one sd_req at 0x1000; 4 wr pulses with matching data, each 1 cycle after sd_valid; done 1 cycle after the last wr.
- Multi-burst: num_words=10 → sd_addr sequence 0x1000, 0x1020, 0x1040; 10 wr pulses; last 2 beats of burst 3 discarded; done once.
- num_words=0 → 32 requests, exactly 128 wr pulses, done; unaligned start_addr=0x1005 → first sd_addr=0x1000.
- Abort after 2 beats of burst 1 (num_words=8) → 0 further wr; remaining 2 beats drained silently; no done; busy falls after the 4th beat; a new start is then accepted.
- start asserted while busy → ignored; address wrap: start_addr=2^ADDR_W-0x20, num_words=8 → second sd_addr=0.
- reset_n low during BEAT → sd_req, wr, busy, done all 0 asynchronously; after release, IDLE accepts start.
